// File: rtl/ex_mem_stage_skid_pkg.sv
// rtl/ex_mem_stage_skid_pkg.sv - shared types and constants for the EX/MEM skid stage
// Purpose: default widths, the EX->MEM payload struct and the skid buffer state encoding.
// Ports: none (package).
package ex_mem_pkg;

    localparam int EX_MEM_XLEN            = 32;
    localparam int EX_MEM_REG_ADDR_WIDTH  = 5;
    localparam int EX_MEM_OP_LEN_WIDTH    = 3;
    localparam int EX_MEM_STALL_CNT_WIDTH = 16;

    typedef struct packed {
        logic [EX_MEM_XLEN-1:0]           result;
        logic [EX_MEM_XLEN-1:0]           rs2_data_forwarded;
        logic [EX_MEM_REG_ADDR_WIDTH-1:0] rd;
        logic                             reg_write;
        logic                             mem_write;
        logic                             mem_read;
        logic [EX_MEM_OP_LEN_WIDTH-1:0]   mem_op_length;
    } ex_mem_payload_t;

    // Bit 0 is the main-register valid, bit 1 the skid-register valid, so
    // ready and valid come straight off state flops.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/ex_mem_stage_skid_if.sv
// rtl/ex_mem_stage_skid_if.sv - EX->MEM handshake and payload bundle
// Purpose: groups the ex_* producer side and mem_* consumer side of the stage.
// Ports: master = EX producer / MEM consumer (testbench side), slave = pipeline stage.
interface ex_mem_stage_skid_if
    import ex_mem_pkg::*;
#(
    parameter int XLEN           = EX_MEM_XLEN,
    parameter int REG_ADDR_WIDTH = EX_MEM_REG_ADDR_WIDTH,
    parameter int OP_LEN_WIDTH   = EX_MEM_OP_LEN_WIDTH
);
    logic                      ex_valid;
    logic                      ex_ready;
    logic [XLEN-1:0]           ex_result;
    logic [XLEN-1:0]           ex_rs2_data_forwarded;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_write;
    logic                      ex_mem_read;
    logic [OP_LEN_WIDTH-1:0]   ex_mem_op_length;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [XLEN-1:0]           mem_result;
    logic [XLEN-1:0]           mem_rs2_data_forwarded;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;
    logic                      mem_mem_write;
    logic                      mem_mem_read;
    logic [OP_LEN_WIDTH-1:0]   mem_mem_op_length;

    modport master (
        output ex_valid, ex_result, ex_rs2_data_forwarded, ex_rd,
               ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_op_length, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_rs2_data_forwarded, mem_rd,
               mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_op_length
    );

    modport slave (
        input  ex_valid, ex_result, ex_rs2_data_forwarded, ex_rd,
               ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_op_length, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_rs2_data_forwarded, mem_rd,
               mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_op_length
    );

endinterface

// File: rtl/ex_mem_stage_skid_pipe_skid_buffer.sv
// rtl/ex_mem_stage_skid_pipe_skid_buffer.sv - two-entry valid/ready skid buffer
// Purpose: main + skid register pair; in_ready depends only on flops.
// Ports: clock, reset_n (async, active-low), flush (sync kill),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module pipe_skid_buffer
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush only drops the valid bits; payload registers keep stale data.
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = SKID_FULL;
                    end else if (out_fire) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage_skid.sv
// rtl/ex_mem_stage_skid.sv - EX/MEM pipeline stage with skid buffer and stall counter
// Purpose: registers the EX payload toward MEM with back-pressure, flush and stall statistics.
// Ports: clock, reset_n (async, active-low), flush, bus (ex_*/mem_* handshake + payload),
//        stall_count_clear, stall_count (saturating count of mem_valid & !mem_ready cycles).
module ex_mem_stage_skid
    import ex_mem_pkg::*;
#(
    parameter int XLEN            = EX_MEM_XLEN,
    parameter int REG_ADDR_WIDTH  = EX_MEM_REG_ADDR_WIDTH,
    parameter int OP_LEN_WIDTH    = EX_MEM_OP_LEN_WIDTH,
    parameter int STALL_CNT_WIDTH = EX_MEM_STALL_CNT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    ex_mem_stage_skid_if.slave         bus,
    input  logic                       stall_count_clear,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);
    typedef struct packed {
        logic [XLEN-1:0]           result;
        logic [XLEN-1:0]           rs2_data_forwarded;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_write;
        logic                      mem_read;
        logic [OP_LEN_WIDTH-1:0]   mem_op_length;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t                   in_payload, out_payload;
    logic                       main_valid;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    assign in_payload = '{
        result:             bus.ex_result,
        rs2_data_forwarded: bus.ex_rs2_data_forwarded,
        rd:                 bus.ex_rd,
        reg_write:          bus.ex_reg_write,
        mem_write:          bus.ex_mem_write,
        mem_read:           bus.ex_mem_read,
        mem_op_length:      bus.ex_mem_op_length
    };

    pipe_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (bus.ex_valid),
        .in_ready  (bus.ex_ready),
        .in_data   (in_payload),
        .out_valid (main_valid),
        .out_ready (bus.mem_ready),
        .out_data  (out_payload)
    );

    assign bus.mem_valid              = main_valid;
    assign bus.mem_result             = out_payload.result;
    assign bus.mem_rs2_data_forwarded = out_payload.rs2_data_forwarded;
    assign bus.mem_rd                 = out_payload.rd;
    assign bus.mem_mem_op_length      = out_payload.mem_op_length;
    // Stale payload bits survive a flush, so side-effecting controls are qualified.
    assign bus.mem_reg_write          = main_valid & out_payload.reg_write;
    assign bus.mem_mem_write          = main_valid & out_payload.mem_write;
    assign bus.mem_mem_read           = main_valid & out_payload.mem_read;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_count_clear) begin
            stall_count_d = '0;
        end else if (main_valid && !bus.mem_ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/ex_mem_stage_skid.md
Name: ex_mem_stage_skid

Overview:
- Parametrised EX/MEM pipeline stage with valid/ready flow control, a one-entry skid buffer, synchronous flush and a saturating stall counter.
- Carries the EX-stage payload to MEM: ALU result, forwarded rs2 data, rd, reg_write, mem_write, mem_read and mem_op_length.
- Lets MEM back-pressure EX without a combinational ready path from mem_ready to ex_ready.

Parameters:
- XLEN, 32, data width of result and rs2 fields.
- REG_ADDR_WIDTH, 5, width of rd.
- OP_LEN_WIDTH, 3, width of mem_op_length.
- STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- ex_valid  in  1  EX payload valid.
- ex_ready  out  1  stage can accept a payload this cycle.
- ex_result  in  XLEN  ALU/address result.
- ex_rs2_data_forwarded  in  XLEN  store data.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- ex_reg_write, ex_mem_write, ex_mem_read  in  1 each  control bits.
- ex_mem_op_length  in  OP_LEN_WIDTH  access size code.
- mem_valid  out  1  output payload valid.
- mem_ready  in  1  MEM consumes the payload this cycle.
- mem_result, mem_rs2_data_forwarded, mem_rd, mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_op_length  out  widths match the ex_* inputs  registered payload.
- stall_count_clear  in  1  synchronous clear of the stall counter.
- stall_count  out  STALL_CNT_WIDTH  number of cycles with mem_valid=1 and mem_ready=0.

Behaviour:
- Storage: main register (drives the mem_* outputs) and skid register, each with its own valid bit.
- Handshakes: in_fire = ex_valid & ex_ready; out_fire = mem_valid & mem_ready.
- ex_ready = !skid_valid, taken directly from a flop, with no combinational dependence on mem_ready.
- mem_valid = main_valid.
- States, derived from the valid bits:
  - EMPTY (main=0, skid=0).
  - ONE (main=1, skid=0).
  - FULL (main=1, skid=1).
- Transitions when flush=0:
  - EMPTY: in_fire -> main<=ex payload, ONE. Otherwise stay.
  - ONE, in_fire & out_fire: main<=ex payload, stay ONE.
  - ONE, in_fire & !out_fire: skid<=ex payload, FULL.
  - ONE, !in_fire & out_fire: EMPTY.
  - ONE, neither: hold.
  - FULL (ex_ready=0): out_fire -> main<=skid, skid_valid<=0, ONE. Otherwise hold.
- Latency and throughput:
  - One cycle from in_fire to mem_valid when the stage is empty.
  - Full throughput of one payload per cycle while mem_ready=1.
  - Payload order is strictly preserved.
- Flush:
  - Highest priority; next state is EMPTY.
  - A payload accepted in the flush cycle is discarded.
  - Payload data registers are not cleared; only the valid bits are.
- Control gating: mem_reg_write, mem_mem_write and mem_mem_read are ANDed with main_valid, so a bubble never writes a register or memory.
- Stall counter:
  - Increments when mem_valid & !mem_ready.
  - Saturates at all-ones; no wrap.
  - stall_count_clear has priority over increment; the counter reads 0 in the following cycle.
  - flush does not affect the counter.
- Reset (reset_n=0, asynchronous):
  - Both valid bits, all payload registers and stall_count go to 0.
  - mem_valid=0, all mem_* outputs=0, ex_ready=1.
  - Reset asserted mid-transfer drops the held payloads.
  - First accept is possible on the first posedge after release.
- ex_* inputs are sampled only on in_fire; values while ex_valid=0 are don't-care.
- mem_* data outputs are stable while mem_valid=1 and mem_ready=0.

Decomposition:
- Package ex_mem_pkg holds:
  - the ex_mem_payload_t struct with fields result, rs2_data_forwarded, rd, reg_write, mem_write, mem_read and mem_op_length;
  - default width constants;
  - the EMPTY/ONE/FULL state encoding.
- Sub-module pipe_skid_buffer, parametrised on payload width, implements the valid/ready skid logic.
- ex_mem_stage_skid contains:
  - the struct packing and unpacking;
  - the control gating;
  - the stall counter.

Test Plan:
1. Reset release, then ex_valid=1 with ex_result=0x0000_1234, rd=5, reg_write=1, mem_ready=1 -> next cycle mem_valid=1, mem_result=0x1234, mem_rd=5, mem_reg_write=1; ex_ready stays 1.
2. Streaming and back-pressure:
   - Stream payloads A, B, C on consecutive cycles with mem_ready=0 from the first posedge on.
   - A goes to main and B to skid; ex_ready=0 after B.
   - C is held upstream; stall_count counts up.
   - Raise mem_ready: outputs A, B, C in order on consecutive cycles, nothing lost or duplicated.
3. Flush with the stage FULL (mem_write=1 in main), together with a new ex_valid -> next cycle mem_valid=0, mem_mem_write=0, ex_ready=1; the new payload never appears at the output.
4. Stall counter with STALL_CNT_WIDTH=4:
   - Hold mem_valid=1 and mem_ready=0 for 20 cycles -> stall_count=15 (saturated).
   - Pulse stall_count_clear -> 0 next cycle.
   - Keep stalling -> counter resumes at 1.
5. Assert reset_n=0 asynchronously between clock edges while FULL -> mem_valid, stall_count and all mem_* outputs are 0 immediately; ex_ready=1.
6. Random ex_valid/mem_ready (10k cycles) checked against a scoreboard FIFO model -> exact order and data match; ex_ready never depends combinationally on mem_ready.
